// File: rtl/mul_booth_seq_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM state codes, Booth digit select codes and the digit-count helper.
package mul_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Booth digit selects: 0, +A, +2A, -A, -2A
    localparam logic [2:0] ZERO = 3'd0;
    localparam logic [2:0] P1   = 3'd1;
    localparam logic [2:0] P2   = 3'd2;
    localparam logic [2:0] M1   = 3'd3;
    localparam logic [2:0] M2   = 3'd4;

    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/mul_booth_seq_if.sv
// Request/response bundle of mul_booth_seq: operand handshake in, product handshake out.
interface mul_booth_seq_if #(
    parameter int WIDTH = 16
);

    logic               in_valid;
    logic               in_ready;
    logic               tc;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, tc, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, tc, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/mul_booth_seq_enc.sv
// Radix-4 Booth digit encoder: maps the triplet {m[2i+1], m[2i], m[2i-1]}
// onto sign / magnitude-1 / magnitude-2 controls for the partial product.
module booth_r4_enc
    import mul_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       neg,
    output logic       one,
    output logic       two
);

    logic [2:0] sel;

    always_comb begin
        case (triplet)
            3'b001, 3'b010: sel = P1;
            3'b011:         sel = P2;
            3'b100:         sel = M2;
            3'b101, 3'b110: sel = M1;
            default:        sel = ZERO;
        endcase
    end

    assign neg = (sel == M1) || (sel == M2);
    assign one = (sel == P1) || (sel == M1);
    assign two = (sel == P2) || (sel == M2);

endmodule

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned
// per request, with valid/ready handshakes on both operand and product sides.
module mul_booth_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    mul_booth_seq_if.slave bus
);

    localparam int ITER = booth_iter(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER);

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [AW-1:0]      acc_q,     acc_d;
    logic [AW-1:0]      mcand_q,   mcand_d;
    logic [EW:0]        mplier_q,  mplier_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;
    logic          neg;
    logic          one;
    logic          two;
    logic [AW-1:0] pp_mag;
    logic [AW-1:0] pp;
    logic [AW-1:0] acc_sum;

    // tc only steers the extension, so its effect is captured in the operand registers
    assign a_ext = bus.tc ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    assign b_ext = bus.tc ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

    booth_r4_enc u_enc (
        .triplet (mplier_q[2:0]),
        .neg     (neg),
        .one     (one),
        .two     (two)
    );

    assign pp_mag  = two ? {mcand_q[AW-2:0], 1'b0} : (one ? mcand_q : '0);
    assign pp      = neg ? (~pp_mag + AW'(1)) : pp_mag;
    assign acc_sum = acc_q + pp;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = product_q;

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{(AW-EW){a_ext[EW-1]}}, a_ext};
                    mplier_d = {b_ext, 1'b0};
                end
            end
            BUSY: begin
                // Multiplicand moves up one digit weight while the multiplier slides down
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[AW-3:0], 2'b00};
                mplier_d = {{2{mplier_q[EW]}}, mplier_q[EW:2]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d   = DONE;
                    product_d = acc_sum[2*WIDTH-1:0];
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking updates so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
        end
    end

endmodule
